// File: rtl/uart_pkt_pkg.sv
// Shared constants and FSM state encoding for the UART packet packer.
// States are plain localparams so legacy blocks can compare against them directly.
package uart_pkt_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned LenW  = 8;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef logic [1:0] pkt_state_t;

  localparam pkt_state_t StIdle    = 2'd0;
  localparam pkt_state_t StLen     = 2'd1;
  localparam pkt_state_t StPayload = 2'd2;
  localparam pkt_state_t StChk     = 2'd3;

endpackage

// File: rtl/uart_pkt_fifo.sv
// Show-ahead word FIFO with full/empty flags; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_pkt_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en, rd_en;

  // Extra pointer MSB tells full apart from empty when the addresses match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

  // Head is forced to zero when empty so stale entries never reach the outputs.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/uart_rx_packer.sv
// Parses sync/length/payload frames from the UART byte strobe and packs payload
// little-endian into FIFO-buffered words. UART_PKT_CHKSUM_EN adds an XOR check byte.
module uart_rx_packer
  import uart_pkt_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_read_buf,
  input  logic [7:0]                    rx_data,
  output logic [ByteW*WORD_BYTES-1:0]   word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          word_last,
  input  logic                          err_clr,
  output logic                          frame_err,
  output logic                          ovf_err,
`ifdef UART_PKT_CHKSUM_EN
  output logic                          chk_err,
`endif
  output logic                          busy
);

  localparam int unsigned WordW = ByteW * WORD_BYTES;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [2:0]      IdxLast = 3'(WORD_BYTES - 1);

  pkt_state_t       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [LenW-1:0]  words_q, words_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WordW-1:0] word_q, word_d;
  logic [WordW-1:0] assembled;
  logic             frame_err_q, ovf_err_q;
  logic             push, push_last, frame_set, ovf_set, timeout, in_frame;
  logic             fifo_full, fifo_empty;
`ifdef UART_PKT_CHKSUM_EN
  logic [7:0]       sum_q, sum_d;
  logic             chk_err_q, chk_set;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    words_d   = words_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    push      = 1'b0;
    push_last = 1'b0;
    frame_set = 1'b0;
`ifdef UART_PKT_CHKSUM_EN
    sum_d     = sum_q;
    chk_set   = 1'b0;
`endif

    assembled = word_q;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (idx_q == 3'(i)) assembled[8*i +: 8] = rx_data;
    end

    in_frame = (state_q != StIdle);
    timeout  = in_frame && !rx_read_buf && (cnt_q == CntLast);
    if (in_frame) cnt_d = rx_read_buf ? '0 : cnt_q + CntOne;

    case (state_q)
      StIdle: begin
        if (rx_read_buf && rx_data == SYNC_BYTE) state_d = StLen;
      end
      StLen: begin
        if (rx_read_buf) begin
          if (rx_data == 8'd0) begin
            frame_set = 1'b1;
            state_d   = StIdle;
          end else begin
            words_d = rx_data;
            idx_d   = 3'd0;
            state_d = StPayload;
`ifdef UART_PKT_CHKSUM_EN
            sum_d   = 8'd0;
`endif
          end
        end
      end
      StPayload: begin
        if (rx_read_buf) begin
          word_d = assembled;
`ifdef UART_PKT_CHKSUM_EN
          sum_d  = sum_q ^ rx_data;
`endif
          if (idx_q == IdxLast) begin
            push      = 1'b1;
            push_last = (words_q == 8'd1);
            idx_d     = 3'd0;
            words_d   = words_q - 8'd1;
`ifdef UART_PKT_CHKSUM_EN
            if (words_q == 8'd1) state_d = StChk;
`else
            if (words_q == 8'd1) state_d = StIdle;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StChk: begin
        if (rx_read_buf) begin
`ifdef UART_PKT_CHKSUM_EN
          chk_set = (rx_data != sum_q);
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A timeout throws away the partial word; words already queued stay put.
    if (timeout) begin
      state_d   = StIdle;
      idx_d     = 3'd0;
      frame_set = 1'b1;
    end
    if (state_d == StIdle) cnt_d = '0;
  end

  assign ovf_set = push && fifo_full && !(word_ready && word_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      words_q     <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      words_q     <= words_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      frame_err_q <= frame_set | (frame_err_q & ~err_clr);
      ovf_err_q   <= ovf_set | (ovf_err_q & ~err_clr);
    end
  end

`ifdef UART_PKT_CHKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q     <= 8'd0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_err_q <= chk_set | (chk_err_q & ~err_clr);
    end
  end

  assign chk_err = chk_err_q;
`endif

  uart_pkt_fifo #(
    .Width (WordW + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i ({push_last, assembled}),
    .pop_i   (word_ready),
    .rdata_o ({word_last, word_data}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign ovf_err    = ovf_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_packer.sv
// Randomized and directed bench for uart_rx_packer: a byte-stream reference model
// fills an expected-word queue that a monitor drains whenever a word is handed over.
module tb_uart_rx_packer;

  localparam int Wb    = 4;
  localparam int Depth = 8;
  localparam int Tmo   = 40;
`ifdef UART_PKT_CHKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_read_buf = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        word_last;
  logic        err_clr = 1'b0;
  logic        frame_err, ovf_err, busy;
`ifdef UART_PKT_CHKSUM_EN
  logic        chk_err;
`endif

  uart_rx_packer #(
    .WORD_BYTES  (Wb),
    .FIFO_DEPTH  (Depth),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_read_buf (rx_read_buf),
    .rx_data     (rx_data),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_last   (word_last),
    .err_clr     (err_clr),
    .frame_err   (frame_err),
    .ovf_err     (ovf_err),
`ifdef UART_PKT_CHKSUM_EN
    .chk_err     (chk_err),
`endif
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the frame as "waiting for sync / length / N payload bytes".
  int          m_phase = 0;   // 0 sync, 1 length, 2 payload, 3 check byte
  int          m_left  = 0;
  int          m_idle  = 0;
  int          m_occ   = 0;
  logic [7:0]  m_bytes[$];
  logic [7:0]  m_xor   = 8'h00;
  bit          m_fe = 0, m_oe = 0, m_ce = 0;
  bit          m_rd, m_wr, fe_set, oe_set, ce_set;
  logic [31:0] m_word;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic [32:0] e;

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_phase = 0; m_left = 0; m_idle = 0; m_occ = 0; m_xor = 8'h00;
      m_fe = 0; m_oe = 0; m_ce = 0;
      m_bytes.delete();
      exp_q.delete();
    end else begin
      m_rd = (m_occ > 0) && word_ready;
      m_wr = 0; fe_set = 0; oe_set = 0; ce_set = 0;
      if (rx_read_buf) begin
        m_idle = 0;
        case (m_phase)
          0: if (rx_data == 8'hA5) m_phase = 1;
          1: begin
            if (rx_data == 8'h00) begin
              fe_set = 1; m_phase = 0;
            end else begin
              m_left = int'(rx_data); m_bytes.delete(); m_xor = 8'h00; m_phase = 2;
            end
          end
          2: begin
            m_bytes.push_back(rx_data);
            m_xor = m_xor ^ rx_data;
            if (m_bytes.size() == Wb) begin
              m_word = 32'h0;
              for (int i = 0; i < Wb; i++) m_word = m_word + (32'(m_bytes[i]) << (8 * i));
              if (m_occ < Depth || m_rd) begin
                exp_q.push_back({(m_left == 1), m_word});
                m_wr = 1;
              end else begin
                oe_set = 1;
              end
              m_bytes.delete();
              m_left--;
              if (m_left == 0) m_phase = ChkEn ? 3 : 0;
            end
          end
          default: begin
            if (rx_data != m_xor) ce_set = 1;
            m_phase = 0;
          end
        endcase
      end else if (m_phase != 0) begin
        m_idle++;
        if (m_idle == Tmo) begin
          fe_set = 1; m_phase = 0; m_bytes.delete();
        end
      end
      if (m_phase == 0) m_idle = 0;
      m_occ = m_occ + int'(m_wr) - int'(m_rd);
      m_fe = fe_set || (m_fe && !err_clr);
      m_oe = oe_set || (m_oe && !err_clr);
      m_ce = ce_set || (m_ce && !err_clr);
    end
  end

  // Monitor: per-cycle status against the model, and word hand-offs against the queue.
  initial forever begin
    @(negedge clock);
    check("valid", word_valid, 64'(m_occ > 0));
    check("busy", busy, 64'(m_phase != 0));
    check("frame_err", frame_err, 64'(m_fe));
    check("ovf_err", ovf_err, 64'(m_oe));
`ifdef UART_PKT_CHKSUM_EN
    check("chk_err", chk_err, 64'(m_ce));
`endif
    if (word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pop: got unexpected word %0h expected none", word_data);
      end else begin
        e = exp_q.pop_front();
        check("word_data", 64'(word_data), 64'(e[31:0]));
        check("word_last", 64'(word_last), 64'(e[32]));
      end
      got_q.push_back({word_last, word_data});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_read_buf = 1'b1;
    rx_data     = b;
    @(posedge clock);
    #1;
    rx_read_buf = 1'b0;
    rx_data     = 8'($urandom);
    tick(gap);
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 11) == 0) return Tmo + 3;
    return int'($urandom_range(0, 2));
  endfunction

  logic [7:0] r_b, r_x;
  int         r_len;
  bit         rand_done = 0;

  initial begin
    // Reset held with strobes toggling: everything stays zero.
    repeat (4) begin
      @(posedge clock); #1;
      rx_read_buf = 1'b1; rx_data = 8'hA5;
    end
    @(negedge clock);
    check("rst word_data", 64'(word_data), 64'h0);
    check("rst word_last", 64'(word_last), 64'h0);
    check("rst word_valid", 64'(word_valid), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    @(posedge clock); #1;
    rx_read_buf = 1'b0;
    #2 reset = 1'b1;
    tick(2);
    check("post-rst busy", 64'(busy), 64'h0);
    check("post-rst valid", 64'(word_valid), 64'h0);

    // Normal two-word frame, back-to-back strobes.
    got_q.delete();
    word_ready = 1'b1;
    send_byte(8'hA5, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    check("t2 no early valid", 64'(word_valid), 64'h0);
    send_byte(8'h44, 0);
    check("t2 valid rise w0", 64'(word_valid), 64'h1);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    check("t2 valid rise w1", 64'(word_valid), 64'h1);
`ifdef UART_PKT_CHKSUM_EN
    send_byte(8'h88, 0);
`endif
    tick(3);
    check("t2 busy", 64'(busy), 64'h0);
    check("t2 count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t2 w0", 64'(got_q[0]), {31'h0, 1'b0, 32'h44332211});
      check("t2 w1", 64'(got_q[1]), {31'h0, 1'b1, 32'h88776655});
    end

    // Backpressure: nine words into an eight-deep FIFO.
    got_q.delete();
    word_ready = 1'b0;
    send_byte(8'hA5, 0); send_byte(8'h09, 0);
    for (int i = 1; i <= 36; i++) send_byte(8'(i), 0);
`ifdef UART_PKT_CHKSUM_EN
    send_byte(8'h00, 0);
`endif
    tick(2);
    check("t3 ovf", 64'(ovf_err), 64'h1);
    check("t3 head", 64'(word_data), 64'h04030201);
    word_ready = 1'b1;
    tick(12);
    check("t3 count", 64'(got_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      m_word = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      check("t3 word", 64'(got_q[k]), {31'h0, 1'b0, m_word});
    end
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    check("t3 ovf cleared", 64'(ovf_err), 64'h0);

    // Zero length and junk.
    got_q.delete();
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'hA5, 0); send_byte(8'h00, 0);
    tick(2);
    check("t4 frame_err", 64'(frame_err), 64'h1);
    check("t4 busy", 64'(busy), 64'h0);
    check("t4 no word", 64'(got_q.size()), 64'd0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    check("t4 cleared", 64'(frame_err), 64'h0);
    send_byte(8'hA5, 1); send_byte(8'h01, 1);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
`ifdef UART_PKT_CHKSUM_EN
    send_byte(8'h22, 0);
`endif
    tick(3);
    check("t4 count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("t4 word", 64'(got_q[0]), {31'h0, 1'b1, 32'hEFBEADDE});

    // Gaps of exactly one cycle under the timeout must not abort.
    got_q.delete();
    send_byte(8'hA5, Tmo - 1); send_byte(8'h01, Tmo - 1);
    send_byte(8'h11, Tmo - 1); send_byte(8'h22, Tmo - 1);
    send_byte(8'h33, Tmo - 1); send_byte(8'h44, 0);
`ifdef UART_PKT_CHKSUM_EN
    send_byte(8'h44, 0);
`endif
    tick(3);
    check("t5 no abort", 64'(frame_err), 64'h0);
    check("t5 count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("t5 word", 64'(got_q[0]), {31'h0, 1'b1, 32'h44332211});

    // Timeout with a partial word pending.
    got_q.delete();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    tick(Tmo - 1);
    check("t5 still busy", 64'(busy), 64'h1);
    tick(1);
    check("t5 timeout busy", 64'(busy), 64'h0);
    check("t5 timeout err", 64'(frame_err), 64'h1);
    check("t5 timeout empty", 64'(word_valid), 64'h0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;

`ifdef UART_PKT_CHKSUM_EN
    got_q.delete();
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h0F, 0);
    tick(2);
    check("t6 chk ok", 64'(chk_err), 64'h0);
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    tick(2);
    check("t6 chk bad", 64'(chk_err), 64'h1);
    check("t6 count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) check("t6 word", 64'(got_q[1]), {31'h0, 1'b1, 32'h08040201});
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
`endif

    // Asynchronous reset mid-frame with a word queued.
    word_ready = 1'b0;
    send_byte(8'hA5, 0); send_byte(8'h03, 0);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
    check("t7 pre valid", 64'(word_valid), 64'h1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("t7 rst valid", 64'(word_valid), 64'h0);
    check("t7 rst busy", 64'(busy), 64'h0);
    check("t7 rst data", 64'(word_data), 64'h0);
    @(posedge clock); #3;
    reset = 1'b1;
    word_ready = 1'b1;
    tick(2);

    // Randomized frames with random gaps, backpressure and error clears.
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          if ($urandom_range(0, 3) == 0) begin
            r_b = 8'($urandom);
            if (r_b == 8'hA5) r_b = 8'h5A;
            send_byte(r_b, rgap());
          end
          send_byte(8'hA5, rgap());
          r_len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
          send_byte(8'(r_len), rgap());
          r_x = 8'h00;
          for (int i = 0; i < r_len * Wb; i++) begin
            r_b = 8'($urandom);
            r_x = r_x ^ r_b;
            send_byte(r_b, rgap());
          end
`ifdef UART_PKT_CHKSUM_EN
          if (r_len != 0) send_byte(($urandom_range(0, 3) == 0) ? 8'($urandom) : r_x, rgap());
`endif
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          word_ready = ($urandom_range(0, 3) != 0);
          err_clr    = ($urandom_range(0, 19) == 0);
        end
      end
    join
    word_ready = 1'b1;
    err_clr    = 1'b0;
    tick(Tmo + 20);
    check("drain valid", 64'(word_valid), 64'h0);
    check("drain queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
